// File: rtl/seg_adder.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands are processed SEG bits per
// clock, rippling a registered carry between segments under a start/busy/done handshake.
module seg_adder #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iStart,
  input  logic             iSub,
  input  logic [WIDTH-1:0] iData_a,
  input  logic [WIDTH-1:0] iData_b,
  input  logic             iC,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oData,
  output logic             oData_C,
  output logic             oOverflow,
  output logic             oZero
);

  localparam int STEPS = WIDTH / SEG;
  localparam int IDXW  = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(STEPS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic [IDXW-1:0]  idx_q;
  logic             carry_q;
  logic             sub_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;
  logic [SEG:0]     seg_sum;
  logic             msb_cin;

  // Operands shift right each step, so the active segment is always in the low SEG bits.
  always_comb begin
    seg_sum = {1'b0, a_q[SEG-1:0]} + {1'b0, b_q[SEG-1:0]} + {{SEG{1'b0}}, carry_q};
    msb_cin = seg_sum[SEG-1] ^ a_q[SEG-1] ^ b_q[SEG-1];
    data_d  = data_q;
    data_d[int'(idx_q) * SEG +: SEG] = seg_sum[SEG-1:0];
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          data_q  <= data_d;
          a_q     <= a_q >> SEG;
          b_q     <= b_q >> SEG;
          carry_q <= seg_sum[SEG];
          idx_q   <= idx_q + 1'b1;
          if (idx_q == LAST) begin
            state_q <= DONE;
            cout_q  <= sub_q ? ~seg_sum[SEG] : seg_sum[SEG];
            ovf_q   <= msb_cin ^ seg_sum[SEG];
            zero_q  <= (data_d == '0);
          end
        end
        default: begin
          // Subtraction runs as A + ~B + ~borrow through the same adder.
          if (iStart) begin
            state_q <= RUN;
            a_q     <= iData_a;
            b_q     <= iSub ? ~iData_b : iData_b;
            carry_q <= iSub ? ~iC : iC;
            sub_q   <= iSub;
            idx_q   <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign oBusy     = (state_q == RUN);
  assign oDone     = (state_q == DONE);
  assign oData     = data_q;
  assign oData_C   = cout_q;
  assign oOverflow = ovf_q;
  assign oZero     = zero_q;

endmodule

// File: tb/tb_seg_adder.sv
// Bench for seg_adder: arithmetic reference model plus a per-cycle compare
// process on the default instance, and directed checks on narrow instances.
module tb_seg_adder;

  typedef struct packed {
    logic [31:0] data;
    logic        c;
    logic        ovf;
    logic        zero;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iStart = 1'b0, iSub = 1'b0, iC = 1'b0;
  logic [31:0] iA = '0, iB = '0;
  logic        oBusy, oDone, oDataC, oOvf, oZero;
  logic [31:0] oData;

  logic        s8Start = 1'b0;
  logic [7:0]  s8A = '0, s8B = '0;
  logic        s8Busy, s8Done, s8C, s8Ovf, s8Zero;
  logic [7:0]  s8Data;

  logic        s16Start = 1'b0;
  logic [15:0] s16A = '0, s16B = '0;
  logic        s16Busy, s16Done, s16C, s16Ovf, s16Zero;
  logic [15:0] s16Data;

  int   checks = 0;
  int   failures = 0;
  logic checking = 1'b0;

  int   busyLeft = 0;
  logic expDone = 1'b0;
  res_t expOut = '0;
  res_t pending = '0;

  always #5 clk = ~clk;

  seg_adder #(.WIDTH(32), .SEG(8)) dut (
    .iClk(clk), .iRst(rst), .iStart(iStart), .iSub(iSub),
    .iData_a(iA), .iData_b(iB), .iC(iC),
    .oBusy(oBusy), .oDone(oDone), .oData(oData),
    .oData_C(oDataC), .oOverflow(oOvf), .oZero(oZero)
  );

  seg_adder #(.WIDTH(8), .SEG(8)) dut8 (
    .iClk(clk), .iRst(rst), .iStart(s8Start), .iSub(1'b0),
    .iData_a(s8A), .iData_b(s8B), .iC(1'b0),
    .oBusy(s8Busy), .oDone(s8Done), .oData(s8Data),
    .oData_C(s8C), .oOverflow(s8Ovf), .oZero(s8Zero)
  );

  seg_adder #(.WIDTH(16), .SEG(4)) dut16 (
    .iClk(clk), .iRst(rst), .iStart(s16Start), .iSub(1'b0),
    .iData_a(s16A), .iData_b(s16B), .iC(1'b0),
    .oBusy(s16Busy), .oDone(s16Done), .oData(s16Data),
    .oData_C(s16C), .oOverflow(s16Ovf), .oZero(s16Zero)
  );

  // Result of a w-bit add/subtract computed with plain integer arithmetic.
  function automatic res_t model(int w, logic sub, logic [31:0] a, logic [31:0] b, logic c);
    res_t   r;
    longint m  = longint'(1) << w;
    longint ua = longint'(a) % m;
    longint ub = longint'(b) % m;
    longint ci = c ? 1 : 0;
    longint sa = (ua >= m / 2) ? ua - m : ua;
    longint sb = (ub >= m / 2) ? ub - m : ub;
    longint u;
    longint s;
    if (sub) begin
      u   = ua - ub - ci;
      s   = sa - sb - ci;
      r.c = (u < 0);
    end else begin
      u   = ua + ub + ci;
      s   = sa + sb + ci;
      r.c = (u >= m);
    end
    u      = ((u % m) + m) % m;
    r.data = 32'(u);
    r.ovf  = (s >= m / 2) || (s < -(m / 2));
    r.zero = (u == 0);
    return r;
  endfunction

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(logic sub, logic [31:0] a, logic [31:0] b, logic c);
    iStart = 1'b1;
    iSub   = sub;
    iA     = a;
    iB     = b;
    iC     = c;
  endtask

  // Issue one operation and count negedges until oDone, bounded.
  task automatic runOp(logic sub, logic [31:0] a, logic [31:0] b, logic c, output int lat);
    applyStimulus(sub, a, b, c);
    lat = 0;
    do begin
      @(negedge clk);
      iStart = 1'b0;
      iA     = $urandom;
      iB     = $urandom;
      lat++;
    end while (!oDone && lat < 40);
  endtask

  task automatic countDones(int cycles, output int n, output logic [31:0] lastData);
    n = 0;
    lastData = '0;
    repeat (cycles) begin
      @(negedge clk);
      if (oDone) begin
        n++;
        lastData = oData;
      end
    end
  endtask

  // Reference handshake: acceptance, STEPS busy cycles, one done cycle.
  always @(posedge clk) begin
    if (rst) begin
      busyLeft = 0;
      expDone  = 1'b0;
      expOut   = '0;
    end else if (busyLeft > 0) begin
      busyLeft--;
      expDone = (busyLeft == 0);
      if (busyLeft == 0) expOut = pending;
    end else begin
      expDone = 1'b0;
      if (iStart) begin
        busyLeft = 4;
        pending  = model(32, iSub, iA, iB, iC);
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      checkOutput("busy", oBusy, busyLeft > 0);
      checkOutput("done", oDone, expDone);
      if (busyLeft == 0) begin
        checkOutput("data", oData, expOut.data);
        checkOutput("carry", oDataC, expOut.c);
        checkOutput("overflow", oOvf, expOut.ovf);
        checkOutput("zero", oZero, expOut.zero);
      end
    end
  end

  initial begin
    int          lat;
    int          n;
    logic [31:0] d;
    res_t        r;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    checking = 1'b1;

    r = model(32, 1'b0, 32'hFFFF_FFFF, 32'h1, 1'b0);
    checkOutput("pin add wrap", r, {32'h0, 1'b1, 1'b0, 1'b1});
    r = model(32, 1'b0, 32'h7FFF_FFFF, 32'h0, 1'b1);
    checkOutput("pin add ovf", r, {32'h8000_0000, 1'b0, 1'b1, 1'b0});
    r = model(32, 1'b1, 32'h5, 32'h7, 1'b0);
    checkOutput("pin sub borrow", r, {32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0});
    r = model(32, 1'b1, 32'h8000_0000, 32'h1, 1'b0);
    checkOutput("pin sub ovf", r, {32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0});

    runOp(1'b0, 32'hFFFF_FFFF, 32'h1, 1'b0, lat);
    checkOutput("t1 latency", lat, 5);
    checkOutput("t1 result", {oData, oDataC, oOvf, oZero}, {32'h0, 1'b1, 1'b0, 1'b1});
    runOp(1'b0, 32'h7FFF_FFFF, 32'h0, 1'b1, lat);
    checkOutput("t2 result", {oData, oDataC, oOvf, oZero}, {32'h8000_0000, 1'b0, 1'b1, 1'b0});
    runOp(1'b1, 32'h5, 32'h7, 1'b0, lat);
    checkOutput("t3 result", {oData, oDataC, oOvf}, {32'hFFFF_FFFE, 1'b1, 1'b0});
    runOp(1'b1, 32'h8000_0000, 32'h1, 1'b0, lat);
    checkOutput("t4 result", {oData, oDataC, oOvf}, {32'h7FFF_FFFF, 1'b0, 1'b1});

    @(negedge clk);
    applyStimulus(1'b0, 32'd1, 32'd2, 1'b0);
    @(negedge clk);
    iStart = 1'b0;
    @(negedge clk);
    applyStimulus(1'b0, 32'd100, 32'd2, 1'b0);
    @(negedge clk);
    iStart = 1'b0;
    countDones(12, n, d);
    checkOutput("busy start ignored dones", n, 1);
    checkOutput("busy start ignored data", d, 32'd3);

    runOp(1'b0, 32'd1, 32'd1, 1'b0, lat);
    runOp(1'b0, 32'd10, 32'd20, 1'b0, lat);
    checkOutput("done-cycle start latency", lat, 5);
    checkOutput("done-cycle start data", oData, 32'd30);

    @(negedge clk);
    applyStimulus(1'b0, 32'd123, 32'd456, 1'b0);
    @(negedge clk);
    iStart = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort outputs", {oBusy, oDone, oData, oDataC, oOvf, oZero}, '0);
    countDones(8, n, d);
    checkOutput("abort no done", n, 0);
    runOp(1'b1, 32'd1000, 32'd1, 1'b1, lat);
    checkOutput("after abort latency", lat, 5);
    checkOutput("after abort data", oData, 32'd998);

    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      iStart = ($urandom_range(0, 2) == 0);
      iSub   = $urandom_range(0, 1);
      iC     = $urandom_range(0, 1);
      case ($urandom_range(0, 4))
        0: iA = 32'h0;
        1: iA = 32'hFFFF_FFFF;
        2: iA = 32'h7FFF_FFFF;
        3: iA = 32'h8000_0000;
        default: iA = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0: iB = 32'h0;
        1: iB = 32'hFFFF_FFFF;
        2: iB = iA;
        3: iB = 32'h8000_0000;
        default: iB = $urandom;
      endcase
    end
    @(negedge clk);
    iStart = 1'b0;
    repeat (8) @(negedge clk);

    r = model(8, 1'b0, 32'h80, 32'h80, 1'b0);
    checkOutput("pin w8", r, {32'h0, 1'b1, 1'b1, 1'b1});
    s8Start = 1'b1;
    s8A = 8'h80;
    s8B = 8'h80;
    lat = 0;
    do begin
      @(negedge clk);
      s8Start = 1'b0;
      lat++;
    end while (!s8Done && lat < 40);
    checkOutput("w8 latency", lat, 2);
    checkOutput("w8 result", {s8Data, s8C, s8Ovf, s8Zero}, {8'h00, 1'b1, 1'b1, 1'b1});

    r = model(16, 1'b0, 32'h0FFF, 32'h1, 1'b0);
    checkOutput("pin w16", r, {32'h1000, 1'b0, 1'b0, 1'b0});
    s16Start = 1'b1;
    s16A = 16'h0FFF;
    s16B = 16'h0001;
    lat = 0;
    do begin
      @(negedge clk);
      s16Start = 1'b0;
      lat++;
    end while (!s16Done && lat < 40);
    checkOutput("w16 latency", lat, 5);
    checkOutput("w16 result", {s16Data, s16C, s16Ovf, s16Zero}, {16'h1000, 1'b0, 1'b0, 1'b0});

    checking = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
